// File: rtl/qq_pq_core_if.sv
// Request/status bundle for the qq_pq_core sorted priority queue.
//   master: drives enq_i, deq_i, din; observes head, handshake pulses and occupancy.
//   slave : the core side of the same signals.
// Signals:
//   enq_i/deq_i/din : requests, sampled only while rdy=1
//   dout            : head entry (0 when empty)
//   rdy             : core idle
//   enq_o/deq_o     : completion pulses
//   ovf_o/udf_o     : rejection pulses (full / empty)
//   full/empty/count: occupancy
interface qq_pq_core_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
);
  localparam int unsigned CW = $clog2(D + 1);

  logic          enq_i;
  logic          deq_i;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          rdy;
  logic          enq_o;
  logic          deq_o;
  logic          ovf_o;
  logic          udf_o;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output enq_i, deq_i, din,
    input  dout, rdy, enq_o, deq_o, ovf_o, udf_o, full, empty, count
  );

  modport slave (
    input  enq_i, deq_i, din,
    output dout, rdy, enq_o, deq_o, ovf_o, udf_o, full, empty, count
  );
endinterface

// File: rtl/qq_pq_core.sv
// Register-array sorted priority queue. Head is always mem[0]; insertion is a
// sequential compare-and-shift scan from the tail toward the head.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : qq_pq_core_if slave (requests, head, pulses, occupancy)
// Parameters:
//   W    : key width
//   D    : depth (>= 2)
//   MODE : 0 = smallest key at head, 1 = largest key at head
module qq_pq_core #(
  parameter int unsigned W    = 8,
  parameter int unsigned D    = 4,
  parameter int unsigned MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  qq_pq_core_if.slave  bus
);

  localparam int unsigned DW = $clog2(D);
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned IW = DW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   mem_q [D];
  logic [W-1:0]   mem_d [D];
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   t_q, t_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           enq_q, enq_d;
  logic           deq_q, deq_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;
  logic           full_q, empty_q;

  logic [DW-1:0]  cur_idx_c;
  logic [DW-1:0]  prev_idx_c;
  logic [W-1:0]   prev_key_c;

  // Strict ordering test: ties never beat, so equal keys keep arrival order.
  function automatic logic beats(input logic [W-1:0] a, input logic [W-1:0] b);
    if (MODE == 0) return a < b;
    else           return a > b;
  endfunction

  // idx never reaches D while scanning, so the low DW bits address the slot.
  assign cur_idx_c  = DW'(idx_q);
  assign prev_idx_c = DW'(idx_q - IW'(1));
  assign prev_key_c = mem_q[prev_idx_c];

  // Next-state, storage update and pulse generation.
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    count_d = count_q;
    t_d     = t_q;
    idx_d   = idx_q;
    enq_d   = 1'b0;
    deq_d   = 1'b0;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.deq_i) begin
          if (count_q != '0) begin
            for (int unsigned i = 0; i < D - 1; i++) begin
              mem_d[DW'(i)] = mem_q[DW'(i + 1)];
            end
            mem_d[DW'(D - 1)] = '0;
            count_d = count_q - CW'(1);
            deq_d   = 1'b1;
          end else begin
            udf_d = 1'b1;
          end
        end
        // Uses post-dequeue count, which makes replace legal when full.
        if (bus.enq_i) begin
          if (count_d != CW'(D)) begin
            t_d     = bus.din;
            idx_d   = IW'(count_d);
            state_d = S_SCAN;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      S_SCAN: begin
        if ((idx_q == '0) || !beats(t_q, prev_key_c)) begin
          mem_d[cur_idx_c] = t_q;
          count_d = count_q + CW'(1);
          enq_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_d[cur_idx_c] = prev_key_c;
          idx_d = idx_q - IW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, storage and registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mem_q   <= '{default: '0};
      count_q <= '0;
      t_q     <= '0;
      idx_q   <= '0;
      enq_q   <= 1'b0;
      deq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      count_q <= count_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
      enq_q   <= enq_d;
      deq_q   <= deq_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      full_q  <= (count_d == CW'(D));
      empty_q <= (count_d == '0);
    end
  end

  assign bus.dout  = mem_q[0];
  assign bus.rdy   = (state_q == S_IDLE);
  assign bus.enq_o = enq_q;
  assign bus.deq_o = deq_q;
  assign bus.ovf_o = ovf_q;
  assign bus.udf_o = udf_q;
  assign bus.full  = full_q;
  assign bus.empty = empty_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_qq_pq_core.sv
// Bench for qq_pq_core: directed vector table on a MODE=0/D=4/W=8 core and a
// MODE=1/D=8/W=16 core, a mid-scan reset sequence, then random traffic on both
// checked against a sorted-queue reference model.
module tb_qq_pq_core;

  typedef struct {
    bit          deq;
    bit          udf;
    bit          ovf;
    bit          enq;
    int          len;
    int unsigned head;
    int          count;
    int          mid;
    bit          full;
    bit          empty;
    bit          rdy;
  } obs_t;

  typedef struct {
    bit          rst_op;
    int          w;
    bit          e;
    bit          d;
    int unsigned key;
    obs_t        x;
  } vec_t;

  logic clk;
  logic rst;

  logic        enq_r [2];
  logic        deq_r [2];
  logic [15:0] din_r [2];

  logic [15:0] dout_w [2];
  logic [3:0]  cnt_w  [2];
  logic        rdy_w  [2];
  logic        enqo_w [2];
  logic        deqo_w [2];
  logic        ovf_w  [2];
  logic        udf_w  [2];
  logic        full_w [2];
  logic        empty_w[2];

  int checks = 0;
  int errors = 0;
  int unsigned mq[$];

  qq_pq_core_if #(.W(8),  .D(4)) b0 ();
  qq_pq_core_if #(.W(16), .D(8)) b1 ();

  qq_pq_core #(.W(8),  .D(4), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  qq_pq_core #(.W(16), .D(8), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  assign b0.enq_i = enq_r[0];
  assign b0.deq_i = deq_r[0];
  assign b0.din   = din_r[0][7:0];
  assign b1.enq_i = enq_r[1];
  assign b1.deq_i = deq_r[1];
  assign b1.din   = din_r[1];

  assign dout_w[0] = 16'(b0.dout);   assign dout_w[1] = b1.dout;
  assign cnt_w[0]  = 4'(b0.count);   assign cnt_w[1]  = b1.count;
  assign rdy_w[0]  = b0.rdy;         assign rdy_w[1]  = b1.rdy;
  assign enqo_w[0] = b0.enq_o;       assign enqo_w[1] = b1.enq_o;
  assign deqo_w[0] = b0.deq_o;       assign deqo_w[1] = b1.deq_o;
  assign ovf_w[0]  = b0.ovf_o;       assign ovf_w[1]  = b1.ovf_o;
  assign udf_w[0]  = b0.udf_o;       assign udf_w[1]  = b1.udf_o;
  assign full_w[0] = b0.full;        assign full_w[1] = b1.full;
  assign empty_w[0]= b0.empty;       assign empty_w[1]= b1.empty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic obs_t mk(bit deq, bit udf, bit ovf, bit enq, int len, int unsigned head,
                              int count, int mid, bit full, bit empty);
    obs_t o;
    o.deq = deq; o.udf = udf; o.ovf = ovf; o.enq = enq; o.len = len; o.head = head;
    o.count = count; o.mid = mid; o.full = full; o.empty = empty; o.rdy = 1'b1;
    return o;
  endfunction

  function automatic vec_t v(int w, bit e, bit d, int unsigned key, obs_t x);
    vec_t r;
    r.rst_op = 1'b0; r.w = w; r.e = e; r.d = d; r.key = key; r.x = x;
    return r;
  endfunction

  function automatic vec_t vrst();
    vec_t r;
    r = v(0, 1'b0, 1'b0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    r.rst_op = 1'b1;
    return r;
  endfunction

  task automatic reset_all();
    for (int i = 0; i < 2; i++) begin
      enq_r[i] = 1'b0; deq_r[i] = 1'b0; din_r[i] = '0;
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One request on core w; observes the pulses one cycle after acceptance and
  // the final state once the core is idle again.
  task automatic op(input int w, input bit e, input bit d, input int unsigned key, output obs_t o);
    int n;
    n = 0;
    while (!rdy_w[w] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("core%0d.rdy_before", w), 32'(rdy_w[w]), 1);
    enq_r[w] = e; deq_r[w] = d; din_r[w] = 16'(key);
    @(negedge clk);
    enq_r[w] = 1'b0; deq_r[w] = 1'b0;
    o.deq = deqo_w[w]; o.udf = udf_w[w]; o.ovf = ovf_w[w]; o.mid = int'(cnt_w[w]);
    o.len = 0;
    while (!rdy_w[w] && o.len < 64) begin
      @(negedge clk);
      o.len++;
    end
    o.enq = enqo_w[w]; o.head = 32'(dout_w[w]); o.count = int'(cnt_w[w]);
    o.full = full_w[w]; o.empty = empty_w[w]; o.rdy = rdy_w[w];
  endtask

  task automatic cmp(input string tag, input obs_t g, input obs_t x);
    chk({tag, ".deq_o"}, 32'(g.deq), 32'(x.deq));
    chk({tag, ".udf_o"}, 32'(g.udf), 32'(x.udf));
    chk({tag, ".ovf_o"}, 32'(g.ovf), 32'(x.ovf));
    chk({tag, ".enq_o"}, 32'(g.enq), 32'(x.enq));
    chk({tag, ".scan_len"}, 32'(g.len), 32'(x.len));
    chk({tag, ".dout"}, g.head, x.head);
    chk({tag, ".count"}, 32'(g.count), 32'(x.count));
    chk({tag, ".count_mid"}, 32'(g.mid), 32'(x.mid));
    chk({tag, ".full"}, 32'(g.full), 32'(x.full));
    chk({tag, ".empty"}, 32'(g.empty), 32'(x.empty));
    chk({tag, ".rdy"}, 32'(g.rdy), 32'(x.rdy));
  endtask

  function automatic bit m_beats(int w, int unsigned a, int unsigned b);
    return (w == 1) ? (a > b) : (a < b);
  endfunction

  // Reference: plain sorted list; new key goes before the first entry it beats.
  task automatic model_step(input int w, input bit e, input bit d, input int unsigned key,
                            output obs_t x);
    int dep;
    int p;
    dep = (w == 1) ? 8 : 4;
    x = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (d) begin
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        x.deq = 1'b1;
      end else begin
        x.udf = 1'b1;
      end
    end
    x.mid = mq.size();
    if (e) begin
      if (mq.size() == dep) begin
        x.ovf = 1'b1;
      end else begin
        p = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
          if (m_beats(w, key, mq[i])) begin
            p = i;
            break;
          end
        end
        x.len = mq.size() - p + 1;
        x.enq = 1'b1;
        mq.insert(p, key);
      end
    end
    x.count = mq.size();
    x.head  = (mq.size() > 0) ? mq[0] : 0;
    x.full  = (mq.size() == dep);
    x.empty = (mq.size() == 0);
  endtask

  vec_t tbl[$];

  initial begin
    obs_t o;
    obs_t x;
    bit   e, d;
    int unsigned key;

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      enq_r[i] = 1'b0; deq_r[i] = 1'b0; din_r[i] = '0;
    end

    // ---- reset state ----
    reset_all();
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("reset%0d.empty", w), 32'(empty_w[w]), 1);
      chk($sformatf("reset%0d.full", w),  32'(full_w[w]),  0);
      chk($sformatf("reset%0d.count", w), 32'(cnt_w[w]),   0);
      chk($sformatf("reset%0d.rdy", w),   32'(rdy_w[w]),   1);
      chk($sformatf("reset%0d.dout", w),  32'(dout_w[w]),  0);
      chk($sformatf("reset%0d.pulses", w),
          32'({enqo_w[w], deqo_w[w], ovf_w[w], udf_w[w]}), 0);
    end

    // ---- directed vectors ----
    // fields: deq udf ovf enq len head count mid full empty
    tbl.push_back(v(0, 1, 0, 5, mk(0, 0, 0, 1, 1, 5, 1, 0, 0, 0)));
    tbl.push_back(v(0, 1, 0, 3, mk(0, 0, 0, 1, 2, 3, 2, 1, 0, 0)));
    tbl.push_back(v(0, 1, 0, 7, mk(0, 0, 0, 1, 1, 3, 3, 2, 0, 0)));
    tbl.push_back(v(0, 1, 0, 3, mk(0, 0, 0, 1, 3, 3, 4, 3, 1, 0)));
    tbl.push_back(v(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 3, 3, 3, 0, 0)));
    tbl.push_back(v(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 5, 2, 2, 0, 0)));
    tbl.push_back(v(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0)));
    tbl.push_back(v(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(0, 1, 0, 3, mk(0, 0, 0, 1, 1, 3, 1, 0, 0, 0)));
    tbl.push_back(v(0, 1, 0, 3, mk(0, 0, 0, 1, 1, 3, 2, 1, 0, 0)));
    tbl.push_back(v(0, 1, 0, 5, mk(0, 0, 0, 1, 1, 3, 3, 2, 0, 0)));
    tbl.push_back(v(0, 1, 0, 7, mk(0, 0, 0, 1, 1, 3, 4, 3, 1, 0)));
    tbl.push_back(v(0, 1, 0, 1, mk(0, 0, 1, 0, 0, 3, 4, 4, 1, 0)));
    tbl.push_back(v(0, 1, 1, 4, mk(1, 0, 0, 1, 3, 3, 4, 3, 1, 0)));
    tbl.push_back(v(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 4, 3, 3, 0, 0)));
    tbl.push_back(v(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 5, 2, 2, 0, 0)));
    tbl.push_back(v(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0)));
    tbl.push_back(v(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(0, 0, 1, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(0, 1, 1, 6, mk(0, 1, 0, 1, 1, 6, 1, 0, 0, 0)));
    tbl.push_back(vrst());
    tbl.push_back(v(1, 1, 0, 32'h0010, mk(0, 0, 0, 1, 1, 32'h0010, 1, 0, 0, 0)));
    tbl.push_back(v(1, 1, 0, 32'hFFFF, mk(0, 0, 0, 1, 2, 32'hFFFF, 2, 1, 0, 0)));
    tbl.push_back(v(1, 1, 0, 32'h0010, mk(0, 0, 0, 1, 1, 32'hFFFF, 3, 2, 0, 0)));
    tbl.push_back(v(1, 1, 0, 32'h0000, mk(0, 0, 0, 1, 1, 32'hFFFF, 4, 3, 0, 0)));
    tbl.push_back(v(1, 0, 1, 0, mk(1, 0, 0, 0, 0, 32'h0010, 3, 3, 0, 0)));
    tbl.push_back(v(1, 0, 1, 0, mk(1, 0, 0, 0, 0, 32'h0010, 2, 2, 0, 0)));
    tbl.push_back(v(1, 0, 1, 0, mk(1, 0, 0, 0, 0, 32'h0000, 1, 1, 0, 0)));
    tbl.push_back(v(1, 0, 1, 0, mk(1, 0, 0, 0, 0, 32'h0000, 0, 0, 0, 1)));

    foreach (tbl[i]) begin
      if (tbl[i].rst_op) begin
        reset_all();
      end else begin
        op(tbl[i].w, tbl[i].e, tbl[i].d, tbl[i].key, o);
        cmp($sformatf("vec%0d", i), o, tbl[i].x);
      end
    end

    // ---- reset asserted during a scan ----
    reset_all();
    op(0, 1'b1, 1'b0, 6, o);
    cmp("midrst.pre", o, mk(0, 0, 0, 1, 1, 6, 1, 0, 0, 0));
    enq_r[0] = 1'b1; din_r[0] = 16'd1;
    @(negedge clk);
    enq_r[0] = 1'b0;
    chk("midrst.scanning", 32'(rdy_w[0]), 0);
    rst = 1'b0;
    #1;
    chk("midrst.count", 32'(cnt_w[0]),   0);
    chk("midrst.empty", 32'(empty_w[0]), 1);
    chk("midrst.full",  32'(full_w[0]),  0);
    chk("midrst.rdy",   32'(rdy_w[0]),   1);
    chk("midrst.dout",  32'(dout_w[0]),  0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    op(0, 1'b1, 1'b0, 9, o);
    cmp("midrst.post", o, mk(0, 0, 0, 1, 1, 9, 1, 0, 0, 0));

    // ---- random traffic against the reference model ----
    for (int w = 0; w < 2; w++) begin
      reset_all();
      mq.delete();
      for (int n = 0; n < 250; n++) begin
        e = ($urandom_range(0, 99) < 60);
        d = ($urandom_range(0, 99) < 40);
        if ($urandom_range(0, 3) == 0) key = $urandom & ((w == 0) ? 32'hFF : 32'hFFFF);
        else                           key = $urandom_range(0, 7);
        model_step(w, e, d, key, x);
        op(w, e, d, key, o);
        cmp($sformatf("rnd%0d_%0d", w, n), o, x);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
